dlx_exec_pipe: RTL and testbench

// - Parametrised DLX execute unit: single-clock, WIDTH-generic successor of the split arith/shift

---
 rtl/dlx_exec_pipe.sv | 177 +++++++++++++++++
 tb/tb_dlx_exec_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_exec_pipe.sv
// DLX execute unit: 2-stage operand/compute pipeline feeding a credit-protected result FIFO.
// Optional rotate ops (class 10 op3 ROL / op4 ROR) when DLX_EXEC_ROT_EN is defined.
module dlx_exec_pipe #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SHAMT_W   = 5,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] mem_read,
  input  logic [6:0]       cntrl_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             carry,
  output logic             zero,
  output logic             mem_wr_en,
  output logic [WIDTH-1:0] mem_write_out
);
  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
  } res_t;

  logic             s1_valid;
  logic [1:0]       s1_cls;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, s1_sdata, s1_mrd;
  logic             s2_valid;
  res_t             s2_res, comp_res, head_q, head_n;
  res_t             fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_after_pop;
  logic             accept, push, pop, in_ready_n;
  logic             unused_rsvd;

  assign unused_rsvd = cntrl_in[0];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign accept = in_valid & in_ready;
  assign push   = s2_valid;
  assign pop    = out_valid & out_ready;

  // Compute datapath (S2 input)
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH:0]     sum_w, diff_w, sll_w, srl_w, sra_w;
  assign amt    = s1_b[SHAMT_W-1:0];
  assign sum_w  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff_w = {1'b0, s1_a} - {1'b0, s1_b};
  assign sll_w  = {1'b0, s1_a} << amt;
  assign srl_w  = {s1_a, 1'b0} >> amt;
  assign sra_w  = $signed({s1_a, 1'b0}) >>> amt;

`ifdef DLX_EXEC_ROT_EN
  localparam int unsigned RAMT_W = SHAMT_W + 1;
  logic [RAMT_W-1:0] ramt;
  logic [WIDTH-1:0]  rol_w, ror_w;
  assign ramt  = RAMT_W'(WIDTH) - {1'b0, amt};
  assign rol_w = (s1_a << amt) | (s1_a >> ramt);
  assign ror_w = (s1_a >> amt) | (s1_a << ramt);
`endif

  always_comb begin
    comp_res = '0;
    unique case (s1_cls)
      2'b00: begin
        case (s1_op)
          3'd0:    begin comp_res.result = sum_w[WIDTH-1:0];  comp_res.carry = sum_w[WIDTH];  end
          3'd1:    begin comp_res.result = diff_w[WIDTH-1:0]; comp_res.carry = diff_w[WIDTH]; end
          3'd2:    comp_res.result = WIDTH'($signed(s1_a) < $signed(s1_b));
          3'd3:    comp_res.result = WIDTH'(s1_a < s1_b);
          default: ;
        endcase
      end
      2'b01: begin
        case (s1_op)
          3'd0:    comp_res.result = s1_a & s1_b;
          3'd1:    comp_res.result = s1_a | s1_b;
          3'd2:    comp_res.result = s1_a ^ s1_b;
          3'd3:    comp_res.result = ~(s1_a | s1_b);
          3'd4:    comp_res.result = s1_b;
          default: ;
        endcase
      end
      2'b10: begin
        case (s1_op)
          3'd0:    begin comp_res.result = sll_w[WIDTH-1:0]; comp_res.carry = sll_w[WIDTH]; end
          3'd1:    begin comp_res.result = srl_w[WIDTH:1];   comp_res.carry = srl_w[0];     end
          3'd2:    begin comp_res.result = sra_w[WIDTH:1];   comp_res.carry = sra_w[0];     end
`ifdef DLX_EXEC_ROT_EN
          3'd3:    begin comp_res.result = rol_w; comp_res.carry = (amt != '0) & rol_w[0];       end
          3'd4:    begin comp_res.result = ror_w; comp_res.carry = (amt != '0) & ror_w[WIDTH-1]; end
`endif
          default: ;
        endcase
      end
      default: begin
        case (s1_op)
          3'd0:    comp_res.result = s1_mrd;
          3'd1:    begin
            comp_res.result = sum_w[WIDTH-1:0];
            comp_res.wr_en  = 1'b1;
            comp_res.wdata  = s1_sdata;
          end
          default: ;
        endcase
      end
    endcase
    comp_res.zero = (comp_res.result == '0);
  end

  // FIFO bookkeeping; head_n is the entry that will sit at the head after this edge
  always_comb begin
    rd_ptr_n      = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    wr_ptr_n      = push ? ptr_inc(wr_ptr) : wr_ptr;
    cnt_after_pop = cnt - CNT_W'(pop);
    cnt_n         = cnt_after_pop + CNT_W'(push);
    head_n        = (cnt_after_pop == '0) ? s2_res : fifo_mem[rd_ptr_n];
    in_ready_n    = (cnt_n + CNT_W'(accept) + CNT_W'(s1_valid)) < CNT_W'(OUT_DEPTH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      cnt       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      head_q    <= '0;
    end else begin
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      cnt       <= cnt_n;
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      in_ready  <= in_ready_n;
      out_valid <= (cnt_n != '0);
      if (cnt_n != '0) head_q <= head_n;
    end
  end

  // Payload registers carry no reset; validity is tracked above
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_cls   <= cntrl_in[6:5];
      s1_op    <= cntrl_in[4:2];
      s1_a     <= src1;
      s1_b     <= cntrl_in[1] ? imm : src2;
      s1_sdata <= src2;
      s1_mrd   <= mem_read;
    end
    if (s1_valid) s2_res <= comp_res;
    if (push) fifo_mem[wr_ptr] <= s2_res;
  end

  assign aluout        = head_q.result;
  assign carry         = head_q.carry;
  assign zero          = head_q.zero;
  assign mem_wr_en     = head_q.wr_en;
  assign mem_write_out = head_q.wdata;
endmodule

// File: tb/tb_dlx_exec_pipe.sv
// Scoreboard bench for dlx_exec_pipe: directed spec cases, backpressure, reset flush, random traffic.
module tb_dlx_exec_pipe;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] src1, src2, imm, mem_read, aluout, mem_write_out;
  logic [6:0]  cntrl_in;
  logic        carry, zero, mem_wr_en;

  dlx_exec_pipe #(.WIDTH(32), .SHAMT_W(5), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .imm(imm), .mem_read(mem_read), .cntrl_in(cntrl_in),
    .out_valid(out_valid), .out_ready(out_ready), .aluout(aluout), .carry(carry),
    .zero(zero), .mem_wr_en(mem_wr_en), .mem_write_out(mem_write_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        we;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  exp_t last_exp = '0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] mkc(input int cls, input int op, input int ui);
    return {2'(cls), 3'(op), 1'(ui), 1'b0};
  endfunction

  // Reference model: bit-serial shifts/rotates, plain arithmetic elsewhere
  function automatic exp_t model(input logic [6:0] c, input logic [31:0] a, input logic [31:0] s2v,
                                 input logic [31:0] im, input logic [31:0] mr);
    exp_t        e = '0;
    logic [31:0] b = c[1] ? im : s2v;
    logic [31:0] r;
    int          n = int'(b[4:0]);
    int          op = int'(c[4:2]);
    case (c[6:5])
      2'b00: begin
        if (op == 0) begin e.res = a + b; e.c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF; end
        else if (op == 1) begin e.res = a - b; e.c = (a < b); end
        else if (op == 2) e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else if (op == 3) e.res = (a < b) ? 32'd1 : 32'd0;
      end
      2'b01: begin
        if (op == 0) e.res = a & b;
        else if (op == 1) e.res = a | b;
        else if (op == 2) e.res = a ^ b;
        else if (op == 3) e.res = ~(a | b);
        else if (op == 4) e.res = b;
      end
      2'b10: begin
        r = a;
        if (op == 0) begin
          for (int i = 0; i < n; i++) begin e.c = r[31]; r = r << 1; end
          e.res = r;
        end else if (op == 1) begin
          for (int i = 0; i < n; i++) begin e.c = r[0]; r = r >> 1; end
          e.res = r;
        end else if (op == 2) begin
          for (int i = 0; i < n; i++) begin e.c = r[0]; r = {r[31], r[31:1]}; end
          e.res = r;
        end
`ifdef DLX_EXEC_ROT_EN
        else if (op == 3) begin
          for (int i = 0; i < n; i++) begin r = {r[30:0], r[31]}; e.c = r[0]; end
          e.res = r;
        end else if (op == 4) begin
          for (int i = 0; i < n; i++) begin r = {r[0], r[31:1]}; e.c = r[31]; end
          e.res = r;
        end
`endif
      end
      default: begin
        if (op == 0) e.res = mr;
        else if (op == 1) begin e.res = a + b; e.we = 1'b1; e.wd = s2v; end
      end
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_op(output logic [6:0] c, output logic [31:0] a, output logic [31:0] b,
                         output logic [31:0] im, output logic [31:0] mr);
    c  = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1))};
    a  = pick_val();
    b  = pick_val();
    im = pick_val();
    mr = $urandom;
  endtask

  task automatic issue(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] mr);
    int w = 0;
    in_valid = 1'b1; cntrl_in = c; src1 = a; src2 = b; imm = im; mem_read = mr;
    while (!in_ready && w < 1000) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    q.push_back(model(c, a, b, im, mr));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 2000) begin @(posedge clk); #1; w++; end
    chk("drain_pending", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: compare whenever the DUT hands over its head entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_pop: got aluout 0x%08h expected no result", aluout);
        end else begin
          e = q.pop_front();
          chk("aluout", aluout, e.res);
          chk("carry", 32'(carry), 32'(e.c));
          chk("zero", 32'(zero), 32'(e.z));
          chk("mem_wr_en", 32'(mem_wr_en), 32'(e.we));
          chk("mem_write_out", mem_write_out, e.wd);
          last_exp = e;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [6:0]  c;
    logic [31:0] a, b, im, mr;
    int          acc;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; imm = '0; mem_read = '0; cntrl_in = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_aluout", aluout, 32'd0);
    chk("rst_flags", {29'd0, carry, zero, mem_wr_en}, 32'd0);
    chk("rst_mem_write_out", mem_write_out, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // First-op latency
    issue(mkc(0, 0, 0), 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
    chk("lat_n1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_n2_pre", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_n2", 32'(out_valid), 32'd1);
    drain();

    issue(mkc(0, 1, 1), 32'd3, 32'h0, 32'd5, 32'h0);
    issue(mkc(0, 2, 0), 32'h8000_0000, 32'd1, 32'h0, 32'h0);
    issue(mkc(2, 2, 0), 32'h8000_0001, 32'd4, 32'h0, 32'h0);
    issue(mkc(2, 0, 0), 32'h8000_0000, 32'd1, 32'h0, 32'h0);
    issue(mkc(2, 3, 0), 32'h8000_0001, 32'd1, 32'h0, 32'h0);
    issue(mkc(2, 4, 0), 32'h8000_0001, 32'd1, 32'h0, 32'h0);
    issue(mkc(2, 3, 0), 32'h1234_5678, 32'd0, 32'h0, 32'h0);
    issue(mkc(2, 1, 0), 32'h0000_00F0, 32'd5, 32'h0, 32'h0);
    issue(mkc(3, 0, 0), 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D);
    issue(mkc(3, 1, 1), 32'h100, 32'hDEAD_BEEF, 32'h8, 32'h0);
    drain();
    // Empty FIFO keeps presenting the last head
    chk("empty_out_valid", 32'(out_valid), 32'd0);
    chk("hold_aluout", aluout, last_exp.res);
    chk("hold_mem_write_out", mem_write_out, last_exp.wd);

    // Backpressure: exactly DEPTH accepts, then in_ready low
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      rand_op(c, a, b, im, mr);
      in_valid = 1'b1; cntrl_in = c; src1 = a; src2 = b; imm = im; mem_read = mr;
      if (in_ready) begin
        q.push_back(model(c, a, b, im, mr));
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", 32'(acc), 32'(DEPTH));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head_stable", aluout, q[0].res);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("bp_pop_rate", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    chk("bp_no_dup", 32'(out_valid), 32'd0);
    chk("bp_queue_empty", 32'(q.size()), 32'd0);

    // Reset with ops in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_op(c, a, b, im, mr);
      issue(mkc(1, 4, 0), a, 32'hFFFF_0000 | 32'(i + 1), im, mr);
    end
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_aluout", aluout, 32'd0);
    chk("mid_rst_flags", {29'd0, carry, zero, mem_wr_en}, 32'd0);
    chk("mid_rst_mem_write_out", mem_write_out, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    end
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Random traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          rand_op(c, a, b, im, mr);
          issue(c, a, b, im, mr);
          if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
